// File: rtl/oh_fifo_reader_if.sv
// Read-port bundle between the async FIFO, the drain engine and the downstream
// access/packet/wait stream. The master modport is the drain engine's view.
interface oh_fifo_reader_if #(
    parameter int DW = 104,
    parameter int AW = 5
);
    logic          fifo_empty;
    logic [AW-1:0] fifo_rd_count;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          access_out;
    logic [DW-1:0] packet_out;
    logic          wait_in;

    modport master (
        input  fifo_empty,
        input  fifo_rd_count,
        input  fifo_dout,
        input  wait_in,
        output fifo_rd_en,
        output access_out,
        output packet_out
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_count,
        output fifo_dout,
        output wait_in,
        input  fifo_rd_en,
        input  access_out,
        input  packet_out
    );
endinterface

// File: rtl/oh_fifo_reader.sv
// Read-side drain engine: bursts FIFO reads into a 2-entry skid buffer that
// feeds an access/packet/wait stream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no reads; idle timer runs while the FIFO holds data
//   S_BURST | reads issued whenever the skid buffer has room; leave on empty
module oh_fifo_reader #(
    parameter int DW      = 104,
    parameter int AW      = 5,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    oh_fifo_reader_if.master io_bus,
    output logic             o_burst_active,
    output logic             o_timeout_event
);
    localparam int              TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   TMO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [AW-1:0]   BURST_LVL = AW'(BURST);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [1:0]      r_occ;
    logic            r_inflight;
    logic [DW-1:0]   r_head;
    logic [DW-1:0]   r_tail;
    logic            r_burst_active;
    logic            r_timeout_event;
    logic            w_pop;
    logic            w_push;
    logic            w_rd_en;
    logic            w_thr_hit;
    logic            w_tmo_hit;
    logic            w_tmo_fire;
    logic [2:0]      w_occ_proj;

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_fire  = 1'b0;
        w_pop       = (r_occ != 2'd0) & ~io_bus.wait_in;
        w_push      = r_inflight;
        // Occupancy once this cycle's capture and transfer have settled;
        // a new read may only launch if its word will still have a slot.
        w_occ_proj  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_thr_hit   = (io_bus.fifo_rd_count >= BURST_LVL);
        w_tmo_hit   = (TIMEOUT != 0) & ~io_bus.fifo_empty & (r_timer == TMO_LAST);

        case (r_state)
            S_IDLE: begin
                if (w_thr_hit) begin
                    w_state_nxt = S_BURST;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_BURST;
                    w_tmo_fire  = 1'b1;
                end
            end
            S_BURST: begin
                if (io_bus.fifo_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_rd_en = (r_state == S_BURST) & ~io_bus.fifo_empty & (w_occ_proj < 3'd2);

        if ((r_state == S_IDLE) && !io_bus.fifo_empty) begin
            w_timer_nxt = (r_timer == '1) ? r_timer : r_timer + 1'b1;
        end else begin
            w_timer_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_timer         <= '0;
            r_inflight      <= 1'b0;
            r_burst_active  <= 1'b0;
            r_timeout_event <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_inflight      <= w_rd_en;
            r_burst_active  <= (r_state == S_BURST);
            r_timeout_event <= w_tmo_fire;
        end
    end

    // Skid buffer: r_head is always the oldest word and drives packet_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= io_bus.fifo_dout;
                    end else begin
                        r_tail <= io_bus.fifo_dout;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= io_bus.fifo_dout;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= io_bus.fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.fifo_rd_en  = w_rd_en;
    assign io_bus.access_out  = (r_occ != 2'd0);
    assign io_bus.packet_out  = r_head;
    assign o_burst_active     = r_burst_active;
    assign o_timeout_event    = r_timeout_event;

    a_occ_max: assert property (@(posedge clk) disable iff (reset) r_occ != 2'd3);
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_pop && (r_occ == 2'd2)));
endmodule

// File: tb/tb_oh_fifo_reader.sv
// Bench for oh_fifo_reader: queue-based FIFO model and scoreboard around a
// burst/timeout instance (BURST=4, TIMEOUT=16) and a streaming one (BURST=1).
module tb_oh_fifo_reader;
    localparam int DW = 104;
    localparam int AW = 5;
    localparam int FIFO_DEPTH = 31;

    typedef logic [DW-1:0] word_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oh_fifo_reader_if #(.DW(DW), .AW(AW)) bus_a ();
    oh_fifo_reader_if #(.DW(DW), .AW(AW)) bus_b ();

    logic ba_a, te_a, ba_b, te_b;

    oh_fifo_reader #(.DW(DW), .AW(AW), .BURST(4), .TIMEOUT(16)) u_dut_a (
        .clk             (clk),
        .reset           (reset),
        .io_bus          (bus_a),
        .o_burst_active  (ba_a),
        .o_timeout_event (te_a)
    );

    oh_fifo_reader #(.DW(DW), .AW(AW), .BURST(1), .TIMEOUT(0)) u_dut_b (
        .clk             (clk),
        .reset           (reset),
        .io_bus          (bus_b),
        .o_burst_active  (ba_b),
        .o_timeout_event (te_b)
    );

    word_t fq_a[$], fq_b[$];
    word_t exp_a[$], got_a[$], exp_b[$], got_b[$];
    int    rd_cyc_a[$], acc_cyc_a[$], te_cyc_a[$], acc_cyc_b[$];
    int    cyc, ba_cnt_a, bad_rd_a, bad_rd_b, occ_bad, te_cnt_b, ba_cnt_b;
    int    checks, errors;

    function automatic word_t rnd_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic upd();
        bus_a.fifo_empty    = (fq_a.size() == 0);
        bus_a.fifo_rd_count = AW'(fq_a.size());
        bus_b.fifo_empty    = (fq_b.size() == 0);
        bus_b.fifo_rd_count = AW'(fq_b.size());
    endtask

    task automatic write_a(input word_t v);
        fq_a.push_back(v);
        exp_a.push_back(v);
        upd();
    endtask

    task automatic write_b(input word_t v);
        fq_b.push_back(v);
        exp_b.push_back(v);
        upd();
    endtask

    task automatic clr();
        exp_a.delete(); got_a.delete(); exp_b.delete(); got_b.delete();
        rd_cyc_a.delete(); acc_cyc_a.delete(); te_cyc_a.delete(); acc_cyc_b.delete();
        ba_cnt_a = 0; bad_rd_a = 0; bad_rd_b = 0; occ_bad = 0; te_cnt_b = 0; ba_cnt_b = 0;
    endtask

    // One clock cycle: drive wait_in, observe the settled cycle, then advance
    // the FIFO model by the pop that the sampled fifo_rd_en requested.
    task automatic tick(input logic w);
        logic rd_a, rd_b;
        bus_a.wait_in = w;
        #1;
        rd_a = bus_a.fifo_rd_en;
        rd_b = bus_b.fifo_rd_en;
        if (rd_a === 1'b1) rd_cyc_a.push_back(cyc);
        if (rd_a === 1'b1 && bus_a.fifo_empty) bad_rd_a++;
        if (rd_b === 1'b1 && bus_b.fifo_empty) bad_rd_b++;
        if (bus_a.access_out === 1'b1) acc_cyc_a.push_back(cyc);
        if (bus_b.access_out === 1'b1) acc_cyc_b.push_back(cyc);
        if (bus_a.access_out === 1'b1 && !w) got_a.push_back(bus_a.packet_out);
        if (bus_b.access_out === 1'b1) got_b.push_back(bus_b.packet_out);
        if (te_a === 1'b1) te_cyc_a.push_back(cyc);
        if (ba_a === 1'b1) ba_cnt_a++;
        if (te_b === 1'b1) te_cnt_b++;
        if (ba_b === 1'b1) ba_cnt_b++;
        if (u_dut_a.r_occ === 2'd3) occ_bad++;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_a === 1'b1 && fq_a.size() > 0) bus_a.fifo_dout = fq_a.pop_front();
        if (rd_b === 1'b1 && fq_b.size() > 0) bus_b.fifo_dout = fq_b.pop_front();
        upd();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick(1'b0);
        checks++; if (bus_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus_a.fifo_rd_en); end
        checks++; if (bus_a.access_out !== 1'b0) begin errors++; $display("FAIL reset_access: got %b want 0", bus_a.access_out); end
        checks++; if (bus_a.packet_out !== '0) begin errors++; $display("FAIL reset_packet: got %h want 0", bus_a.packet_out); end
        checks++; if (ba_a !== 1'b0) begin errors++; $display("FAIL reset_burst_active: got %b want 0", ba_a); end
        checks++; if (te_a !== 1'b0) begin errors++; $display("FAIL reset_timeout_event: got %b want 0", te_a); end
        checks++; if (bus_b.access_out !== 1'b0) begin errors++; $display("FAIL reset_access_b: got %b want 0", bus_b.access_out); end
        reset = 1'b0;
        repeat (3) tick(1'b0);
        checks++; if (bus_a.access_out !== 1'b0) begin errors++; $display("FAIL idle_access: got %b want 0", bus_a.access_out); end
        checks++; if (ba_a !== 1'b0) begin errors++; $display("FAIL idle_burst_active: got %b want 0", ba_a); end
    endtask

    task automatic test_threshold();
        int t4;
        clr();
        t4 = 0;
        for (int i = 0; i < 4; i++) begin
            write_a(word_t'(8'hA0 + i));
            if (i == 3) t4 = cyc;
            tick(1'b0);
        end
        repeat (12) tick(1'b0);
        checks++; if (rd_cyc_a.size() !== 4) begin errors++; $display("FAIL thr_rd_count: got %0d want 4", rd_cyc_a.size()); end
        for (int i = 0; i < 4 && i < rd_cyc_a.size(); i++) begin
            checks++; if (rd_cyc_a[i] !== t4 + 1 + i) begin errors++; $display("FAIL thr_rd_cycle%0d: got %0d want %0d", i, rd_cyc_a[i], t4 + 1 + i); end
        end
        checks++; if (acc_cyc_a.size() !== 4) begin errors++; $display("FAIL thr_access_cycles: got %0d want 4", acc_cyc_a.size()); end
        if (acc_cyc_a.size() > 0) begin
            checks++; if (acc_cyc_a[0] !== t4 + 3) begin errors++; $display("FAIL thr_first_access: got %0d want %0d", acc_cyc_a[0], t4 + 3); end
        end
        checks++; if (got_a.size() !== exp_a.size()) begin errors++; $display("FAIL thr_words: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL thr_word%0d: got %h want %h", i, got_a[i], exp_a[i]); end
        end
        checks++; if (ba_cnt_a !== 5) begin errors++; $display("FAIL thr_burst_active_cycles: got %0d want 5", ba_cnt_a); end
        checks++; if (ba_a !== 1'b0) begin errors++; $display("FAIL thr_end_burst_active: got %b want 0", ba_a); end
        checks++; if (te_cyc_a.size() !== 0) begin errors++; $display("FAIL thr_no_timeout: got %0d want 0", te_cyc_a.size()); end
    endtask

    task automatic test_timeout();
        int c0;
        clr();
        write_a(rnd_word());
        c0 = cyc;
        repeat (30) tick(1'b0);
        checks++; if (te_cyc_a.size() !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d want 1", te_cyc_a.size()); end
        if (te_cyc_a.size() > 0) begin
            checks++; if (te_cyc_a[0] !== c0 + 16) begin errors++; $display("FAIL tmo_cycle: got %0d want %0d", te_cyc_a[0], c0 + 16); end
        end
        checks++; if (rd_cyc_a.size() !== 1) begin errors++; $display("FAIL tmo_rd_count: got %0d want 1", rd_cyc_a.size()); end
        if (rd_cyc_a.size() > 0 && acc_cyc_a.size() > 0) begin
            checks++; if (rd_cyc_a[0] !== c0 + 16) begin errors++; $display("FAIL tmo_rd_cycle: got %0d want %0d", rd_cyc_a[0], c0 + 16); end
            checks++; if (acc_cyc_a[0] !== c0 + 18) begin errors++; $display("FAIL tmo_data_latency: got %0d want %0d", acc_cyc_a[0], c0 + 18); end
        end
        checks++; if (got_a.size() !== 1) begin errors++; $display("FAIL tmo_words: got %0d want 1", got_a.size()); end
        if (got_a.size() > 0) begin
            checks++; if (got_a[0] !== exp_a[0]) begin errors++; $display("FAIL tmo_word: got %h want %h", got_a[0], exp_a[0]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        clr();
        for (int i = 0; i < 8; i++) write_a(rnd_word());
        n = 0;
        while (bus_a.access_out !== 1'b1 && n < 10) begin
            tick(1'b0);
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL bp_access_rise: got %0d cycles want 3", n); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus_a.packet_out !== exp_a[0]) begin errors++; $display("FAIL bp_hold%0d: got %h want %h", i, bus_a.packet_out, exp_a[0]); end
            tick(1'b1);
        end
        checks++; if (rd_cyc_a.size() !== 2) begin errors++; $display("FAIL bp_rd_during_stall: got %0d want 2", rd_cyc_a.size()); end
        repeat (25) tick(1'b0);
        checks++; if (got_a.size() !== exp_a.size()) begin errors++; $display("FAIL bp_words: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, got_a[i], exp_a[i]); end
        end
        checks++; if (rd_cyc_a.size() !== 8) begin errors++; $display("FAIL bp_rd_total: got %0d want 8", rd_cyc_a.size()); end
    endtask

    task automatic test_toggle();
        clr();
        for (int i = 0; i < 20; i++) write_a(rnd_word());
        for (int i = 0; i < 100; i++) tick(logic'(i % 2 == 0));
        checks++; if (got_a.size() !== exp_a.size()) begin errors++; $display("FAIL tog_words: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL tog_word%0d: got %h want %h", i, got_a[i], exp_a[i]); end
        end
        checks++; if (bad_rd_a !== 0) begin errors++; $display("FAIL tog_rd_while_empty: got %0d want 0", bad_rd_a); end
        checks++; if (occ_bad !== 0) begin errors++; $display("FAIL tog_occ_over_2: got %0d want 0", occ_bad); end
        checks++; if (rd_cyc_a.size() !== 20) begin errors++; $display("FAIL tog_rd_total: got %0d want 20", rd_cyc_a.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        clr();
        for (int i = 0; i < 10; i++) write_a(rnd_word());
        n = 0;
        while (bus_a.access_out !== 1'b1 && n < 10) begin
            tick(1'b0);
            n++;
        end
        checks++; if (bus_a.access_out !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got %b want 1", bus_a.access_out); end
        reset = 1'b1;
        tick(1'b1);
        reset = 1'b0;
        #1;
        checks++; if (bus_a.access_out !== 1'b0) begin errors++; $display("FAIL rst_mid_access: got %b want 0", bus_a.access_out); end
        checks++; if (bus_a.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en: got %b want 0", bus_a.fifo_rd_en); end
        checks++; if (ba_a !== 1'b0) begin errors++; $display("FAIL rst_mid_burst_active: got %b want 0", ba_a); end
        // Words already popped are lost; what remains in the FIFO must drain intact.
        got_a.delete();
        exp_a = fq_a;
        repeat (30) tick(1'b0);
        checks++; if (got_a.size() !== exp_a.size()) begin errors++; $display("FAIL rst_mid_words: got %0d want %0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            checks++; if (got_a[i] !== exp_a[i]) begin errors++; $display("FAIL rst_mid_word%0d: got %h want %h", i, got_a[i], exp_a[i]); end
        end
    endtask

    task automatic test_streaming();
        int c0;
        clr();
        write_b(rnd_word());
        c0 = cyc;
        repeat (6) tick(1'b0);
        checks++; if (acc_cyc_b.size() < 1) begin errors++; $display("FAIL str_no_data: got %0d want >=1", acc_cyc_b.size()); end
        if (acc_cyc_b.size() > 0) begin
            checks++; if (acc_cyc_b[0] !== c0 + 3) begin errors++; $display("FAIL str_first_latency: got %0d want %0d", acc_cyc_b[0], c0 + 3); end
        end
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1 && fq_b.size() < FIFO_DEPTH) write_b(rnd_word());
            tick(1'b0);
        end
        repeat (10) tick(1'b0);
        checks++; if (got_b.size() !== exp_b.size()) begin errors++; $display("FAIL str_words: got %0d want %0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            checks++; if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL str_word%0d: got %h want %h", i, got_b[i], exp_b[i]); end
        end
        checks++; if (bad_rd_b !== 0) begin errors++; $display("FAIL str_rd_while_empty: got %0d want 0", bad_rd_b); end
        checks++; if (te_cnt_b !== 0) begin errors++; $display("FAIL str_timeout_disabled: got %0d want 0", te_cnt_b); end
        checks++; if (ba_cnt_b < 1) begin errors++; $display("FAIL str_burst_active_seen: got %0d want >=1", ba_cnt_b); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        bus_a.wait_in   = 1'b0;
        bus_b.wait_in   = 1'b0;
        bus_a.fifo_dout = '0;
        bus_b.fifo_dout = '0;
        clr();
        upd();
        test_reset();
        test_threshold();
        test_timeout();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
